memsplit_dma: RTL



---
 rtl/memsplit_dma_pkg.sv | 28 ++
 rtl/bus_watchdog.sv | 40 ++++
 rtl/memsplit_dma.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/memsplit_dma_pkg.sv
//------------------------------------------------------------------------------
// memsplit_dma_pkg
// Shared types and constants for the MemSplit32 word-copy DMA initiator.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package memsplit_dma_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [3:0]  BE_FULL    = 4'hF;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_watchdog.sv
//------------------------------------------------------------------------------
// bus_watchdog
// Clearable cycle counter; pulses expired on the LIMIT-th enabled cycle
// without a clear.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic arst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int             CW   = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_count <= '0;
        end else if (!enable || clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = enable && (r_count == LAST);

endmodule

`default_nettype wire

// File: rtl/memsplit_dma.sv
//------------------------------------------------------------------------------
// memsplit_dma
// Word-copy DMA initiator on the MemSplit32 split request/response bus.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module memsplit_dma
    import memsplit_dma_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_bi,
    input  logic [31:0]          dst_addr_bi,
    input  logic [LEN_WIDTH-1:0] len_bi,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 bus_req_o,
    output logic                 bus_we_o,
    output logic [31:0]          bus_addr_bo,
    output logic [3:0]           bus_be_bo,
    output logic [31:0]          bus_wdata_bo,
    input  logic                 bus_ack_i,
    input  logic                 bus_resp_i,
    input  logic [31:0]          bus_rdata_bi
);

    state_t               r_state;
    state_t               w_state_next;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [LEN_WIDTH-1:0] r_rem;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic                 r_req;
    logic                 r_we;
    logic [31:0]          w_addr_next;
    logic                 w_start;
    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_rd_resp;
    logic                 w_progress;
    logic                 w_active;
    logic                 w_expired;

    assign w_start    = (r_state == IDLE) && start_i;
    assign w_rd_acc   = (r_state == RD_REQ) && r_req && bus_ack_i;
    assign w_wr_acc   = (r_state == WR_REQ) && r_req && bus_ack_i;
    assign w_rd_resp  = (r_state == RD_WAIT) && bus_resp_i;
    assign w_progress = w_rd_acc || w_wr_acc || w_rd_resp;
    assign w_active   = (r_state == RD_REQ) || (r_state == RD_WAIT) || (r_state == WR_REQ);

    bus_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk_i),
        .arst_n  (arst_n_i),
        .enable  (w_active),
        .clear   (w_progress),
        .expired (w_expired)
    );

    // Handshake progress takes priority over a timeout landing in the same cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start_i) w_state_next = (len_bi == '0) ? DONE : RD_REQ;
            RD_REQ:  if (w_rd_acc) w_state_next = RD_WAIT;
                     else if (w_expired) w_state_next = ERR;
            RD_WAIT: if (w_rd_resp) w_state_next = WR_REQ;
                     else if (w_expired) w_state_next = ERR;
            WR_REQ:  if (w_wr_acc) w_state_next = (r_rem == LEN_WIDTH'(1)) ? DONE : RD_REQ;
                     else if (w_expired) w_state_next = ERR;
            DONE:    w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_addr_next = r_addr;
        if (w_state_next == RD_REQ) begin
            w_addr_next = (r_state == IDLE) ? word_align(src_addr_bi) : r_src;
        end else if (w_state_next == WR_REQ) begin
            w_addr_next = r_dst;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_busy  <= (w_state_next == RD_REQ) || (w_state_next == RD_WAIT) ||
                       (w_state_next == WR_REQ);
            r_done  <= (w_state_next == DONE) || (w_state_next == ERR);
            r_req   <= (w_state_next == RD_REQ) || (w_state_next == WR_REQ);
            r_we    <= (w_state_next == WR_REQ);
            if (w_start) begin
                r_src <= word_align(src_addr_bi);
                r_dst <= word_align(dst_addr_bi);
                r_rem <= len_bi;
                r_err <= 1'b0;
            end
            if (w_rd_acc) r_src <= r_src + WORD_BYTES;
            if (w_wr_acc) begin
                r_dst <= r_dst + WORD_BYTES;
                r_rem <= r_rem - LEN_WIDTH'(1);
            end
            if (w_rd_resp) r_wdata <= bus_rdata_bi;
            if (w_active && (w_state_next == ERR)) r_err <= 1'b1;
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign bus_req_o    = r_req;
    assign bus_we_o     = r_we;
    assign bus_addr_bo  = r_addr;
    assign bus_be_bo    = BE_FULL;
    assign bus_wdata_bo = r_wdata;

endmodule

`default_nettype wire
